// File: rtl/pipeline_if.sv
// Instruction-fetch stage: PC register, instruction-memory read, fetch register to decode,
// load-use bubble insertion with one-cycle replay, and squash on execute-stage redirect.
module pipeline_if #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        valid_stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic [5:0]  id_main_opcode_i,
    input  logic [4:0]  id_rd_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        stall_load_o
);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_REPLAY = 1'b1
    } state_t;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pcq;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pcq_nxt;

    logic        w_load;
    logic        w_rs1_use;
    logic        w_rs2_use;
    logic        w_hz;

    // Decode's registered opcode is one instruction ahead of r_instr.
    assign w_load    = (id_main_opcode_i[5:3] == 3'b100) && (id_rd_i != 5'd0);
    assign w_rs1_use = (r_instr[6:0] != OP_LUI) && (r_instr[6:0] != OP_AUIPC) &&
                       (r_instr[6:0] != OP_JAL);
    assign w_rs2_use = (r_instr[6:2] == 5'b11000) || (r_instr[6:2] == 5'b01100) ||
                       (r_instr[6:2] == 5'b01000);
    assign w_hz      = w_load && (r_state == ST_NORMAL) &&
                       ((w_rs1_use && (r_instr[19:15] == id_rd_i)) ||
                        (w_rs2_use && (r_instr[24:20] == id_rd_i)));

    assign imem_addr_o  = r_pc;
    assign instr_o      = (redirect_i || w_hz) ? NOP_INSTR : r_instr;
    assign pc_o         = r_pcq;
    assign stall_load_o = (r_state == ST_REPLAY) && !redirect_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_NORMAL;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_pcq   <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_pcq   <= w_pcq_nxt;
        end
    end

    // A global freeze outranks everything; the redirect/hazard sources keep their requests up.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_pcq_nxt   = r_pcq;
        if (valid_stall_i) begin
            w_state_nxt = r_state;
        end else if (redirect_i) begin
            w_pc_nxt    = redirect_pc_i;
            w_instr_nxt = NOP_INSTR;
            w_state_nxt = ST_NORMAL;
        end else if (w_hz) begin
            w_state_nxt = ST_REPLAY;
        end else begin
            w_instr_nxt = imem_data_i;
            w_pcq_nxt   = r_pc;
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = ST_NORMAL;
        end
    end

endmodule

// File: doc/pipeline_if.md
# pipeline_if

Instruction-fetch stage of the five-stage RV32I pipeline. Holds the program counter, reads the instruction memory, and presents an instruction/PC pair to the decode stage every cycle. It detects load-use hazards against the instruction currently in decode's output register, inserting one NOP bubble and flagging the replayed instruction with `stall_load_o`. It also squashes wrong-path fetches on a redirect from the execute stage.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `NOP_INSTR`, 32'h0000_0013, bubble/squash encoding (addi x0,x0,0)

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge
- `reset_i`  in  1  synchronous, active-high reset
- `imem_addr_o`  out  32  byte address of the word being fetched (= pc_r)
- `imem_data_i`  in  32  instruction word for `imem_addr_o`, valid combinationally in the same cycle
- `valid_stall_i`  in  1  global freeze; all state holds
- `redirect_i`  in  1  taken branch/jump resolved in EX
- `redirect_pc_i`  in  32  target address, qualified by `redirect_i`
- `id_main_opcode_i`  in  6  decode stage's registered main opcode (instruction one ahead)
- `id_rd_i`  in  5  decode stage's registered rd
- `instr_o`  out  32  instruction to decode
- `pc_o`  out  32  PC of `instr_o`
- `stall_load_o`  out  1  high when `instr_o` is the replay following a load-use bubble

## Operation
- State: `pc_r`, fetch register (`instr_r`, `pcq_r`), `bub_r` (0 = NORMAL, 1 = REPLAY).
- Reset: `pc_r`=RESET_PC, `instr_r`=NOP_INSTR, `pcq_r`=0, `bub_r`=0. Resulting outputs: `instr_o`=NOP_INSTR, `pc_o`=0, `stall_load_o`=0, `imem_addr_o`=RESET_PC.
- Load detect: `id_main_opcode_i[5:3]==3'b100` and `id_rd_i!=0`.
- rs1 use: `instr_r[6:0]` is not LUI (0110111), AUIPC (0010111) or JAL (1101111).
- rs2 use: `instr_r[6:2]` is 11000, 01100 or 01000.
- Hazard `hz`: load detect, `bub_r==0`, and either (rs1 use and `instr_r[19:15]==id_rd_i`) or (rs2 use and `instr_r[24:20]==id_rd_i`).
- Combinational outputs:
  - `instr_o` = NOP_INSTR if `redirect_i` or `hz`, else `instr_r`.
  - `pc_o` = `pcq_r`.
  - `stall_load_o` = `bub_r & ~redirect_i`.
- Next-state priority (highest first):
  1. `valid_stall_i`: every register holds, including `bub_r`. Redirect and hazard are ignored; the sources keep them asserted.
  2. `redirect_i`: `pc_r`←`redirect_pc_i`, `instr_r`←NOP_INSTR, `pcq_r`←`pcq_r`, `bub_r`←0.
  3. `hz`: `pc_r`, `instr_r` and `pcq_r` hold; `bub_r`←1 (NORMAL→REPLAY).
  4. Otherwise: `instr_r`←`imem_data_i`, `pcq_r`←`pc_r`, `pc_r`←`pc_r`+4 (mod 2^32, wraps FFFF_FFFC→0), `bub_r`←0 (REPLAY→NORMAL).
- While in REPLAY, hazard detection is suppressed. The bubble advances `id_main_opcode_i` to NOP, so no re-trigger. Back-to-back dependent loads each get exactly one bubble.
- `redirect_pc_i[1:0]` is not checked; it is used as given.

## Timing
- Fetch-to-decode latency: one cycle. Word at `pc_r` in cycle t appears on `instr_o` in t+1.
- Load-use:
  - Cycle t: `hz`=1, `instr_o`=NOP.
  - Cycle t+1: same `instr_o`/`pc_o` re-presented with `stall_load_o`=1.
  - Cycle t+2: fetch resumes. Exactly one bubble.
- Redirect in cycle t: `instr_o`=NOP in t and t+1; target instruction on `instr_o` in t+2 with `pc_o`=target.
- Redirect in the same cycle as `hz`: redirect wins, no REPLAY entered.
- Redirect during REPLAY: the replayed instruction is squashed, `stall_load_o`=0, `bub_r`→0.
- Reset mid-operation: all state returns to reset values at the next edge; any pending REPLAY is lost.

## Test plan
- Reset, imem returns `addi x1,x0,1` at 0, `addi x2,x0,2` at 4: `imem_addr_o` 0,4,8…; `instr_o` NOP, then 0x00100093 with `pc_o`=0, then 0x00200113 with `pc_o`=4.
- `id_main_opcode_i`=6'b100010, `id_rd_i`=5 with `instr_r`=`add x6,x5,x7`: one cycle `instr_o`=NOP, PC held; next cycle `add` with `stall_load_o`=1; then normal flow.
- Same load with `id_rd_i`=0, or `instr_r`=`lui x5,…`, or rs2 match on an I-type: no bubble, `stall_load_o`=0.
- `redirect_i`=1, `redirect_pc_i`=0x100 at cycle t: `instr_o`=NOP at t and t+1; `imem_addr_o`=0x100 at t+1; `pc_o`=0x100 at t+2.
- `valid_stall_i` held 3 cycles mid-stream, including during REPLAY: all outputs frozen; REPLAY completes exactly once after release.
- Redirect asserted together with a hazard, and again during REPLAY: no bubble or replay; `stall_load_o` stays 0; target fetched.
